// File: rtl/btn_event_scheduler.sv
// btn_event_scheduler
// Converts debounced button levels into press / release / auto-repeat events,
// serialises them through a round-robin arbiter into a small FWFT FIFO and
// hands them to the game logic over a valid/ready handshake.
// Optional feature macro: BTN_AUTOREPEAT_EN builds the millisecond prescaler,
// per-button hold counters and repeat events. Without it only press and
// release events exist and REPEAT_DELAY_MS / REPEAT_RATE_MS are ignored.
module btn_event_scheduler #(
  parameter int unsigned NUM_BTNS        = 4,
  parameter int unsigned CLKIN_FREQ      = 27000000,
  parameter int unsigned REPEAT_DELAY_MS = 400,
  parameter int unsigned REPEAT_RATE_MS  = 100,
  parameter int unsigned FIFO_DEPTH      = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NUM_BTNS-1:0] btnLevel,
  output logic                evtValid,
  input  logic                evtReady,
  output logic [2:0]          evtBtn,
  output logic [1:0]          evtType,
  output logic                evtDropped,
  input  logic                dropClr
);

  typedef enum logic [1:0] {
    EVT_NONE    = 2'b00,
    EVT_PRESS   = 2'b01,
    EVT_RELEASE = 2'b10,
    EVT_REPEAT  = 2'b11
  } evt_t;

  localparam int unsigned AW = $clog2(FIFO_DEPTH);

  // Edge detection
  logic [NUM_BTNS-1:0] btn_q;
  logic [NUM_BTNS-1:0] press_evt;
  logic [NUM_BTNS-1:0] rel_evt;
  logic [NUM_BTNS-1:0] rep_evt;

  // Pending slots and arbitration
  evt_t                slot    [NUM_BTNS];
  evt_t                new_evt [NUM_BTNS];
  logic [2:0]          last_grant;
  logic                found;
  logic                grant;
  logic [2:0]          grant_idx;
  evt_t                grant_type;
  logic                drop_set;

  // Event FIFO
  logic [4:0]          mem [FIFO_DEPTH];
  logic [AW-1:0]       wr_ptr;
  logic [AW-1:0]       rd_ptr;
  logic [AW:0]         count;
  logic                full;
  logic                pop;
  logic                can_push;
  logic [4:0]          head;

  assign press_evt = btnLevel & ~btn_q;
  assign rel_evt   = ~btnLevel & btn_q;

  // Level history; reset loads the live level so buttons held through reset stay silent
  always_ff @(posedge clk) begin
    if (!reset) btn_q <= btnLevel;
    else        btn_q <= btnLevel;
  end

`ifdef BTN_AUTOREPEAT_EN
  localparam int unsigned TICK_CYC = CLKIN_FREQ / 1000;
  localparam int unsigned TW       = (TICK_CYC > 1) ? $clog2(TICK_CYC) : 1;
  localparam int unsigned HOLD_MAX = (REPEAT_DELAY_MS > REPEAT_RATE_MS) ?
                                     REPEAT_DELAY_MS : REPEAT_RATE_MS;
  localparam int unsigned CW       = $clog2(HOLD_MAX + 1);

  logic [TW-1:0]       pre_cnt;
  logic                tick;
  logic [CW-1:0]       hold_cnt [NUM_BTNS];
  logic [NUM_BTNS-1:0] first_done;
  logic [NUM_BTNS-1:0] tracked;
  logic [NUM_BTNS-1:0] held;

  assign tick = (pre_cnt == TW'(TICK_CYC - 1));
  // Only buttons whose press was seen since reset count as held, so a button
  // already down at reset release produces neither a press nor repeats.
  assign held = btnLevel & btn_q & tracked;

  // Free-running millisecond prescaler
  always_ff @(posedge clk) begin
    if (!reset)    pre_cnt <= '0;
    else if (tick) pre_cnt <= '0;
    else           pre_cnt <= pre_cnt + 1'b1;
  end

  // Repeat fires on the tick that completes the active hold threshold
  always_comb begin
    rep_evt = '0;
    for (int unsigned i = 0; i < NUM_BTNS; i++) begin
      rep_evt[i] = held[i] && tick &&
                   (hold_cnt[i] == (first_done[i] ? CW'(REPEAT_RATE_MS - 1)
                                                  : CW'(REPEAT_DELAY_MS - 1)));
    end
  end

  // Per-button hold counters, first-repeat flags and press tracking
  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < NUM_BTNS; i++) begin
      if (!reset || !btnLevel[i]) begin
        hold_cnt[i]   <= '0;
        first_done[i] <= 1'b0;
        tracked[i]    <= 1'b0;
      end else if (press_evt[i]) begin
        hold_cnt[i]   <= '0;
        tracked[i]    <= 1'b1;
      end else if (rep_evt[i]) begin
        hold_cnt[i]   <= '0;
        first_done[i] <= 1'b1;
      end else if (held[i] && tick) begin
        hold_cnt[i]   <= hold_cnt[i] + 1'b1;
      end
    end
  end
`else
  // Auto-repeat not built: no repeat events
  always_comb rep_evt = '0;
`endif

  // Per-button event this cycle; release outranks repeat
  always_comb begin
    for (int unsigned i = 0; i < NUM_BTNS; i++) begin
      new_evt[i] = EVT_NONE;
      if (rel_evt[i])        new_evt[i] = EVT_RELEASE;
      else if (press_evt[i]) new_evt[i] = EVT_PRESS;
      else if (rep_evt[i])   new_evt[i] = EVT_REPEAT;
    end
  end

  assign pop      = evtValid && evtReady;
  assign full     = (count == (AW+1)'(FIFO_DEPTH));
  assign can_push = !full || pop;
  assign grant    = found && can_push;

  // Round-robin scan: buttons above last_grant first, then wrap to the rest
  always_comb begin
    found      = 1'b0;
    grant_idx  = '0;
    grant_type = EVT_NONE;
    for (int unsigned i = 0; i < NUM_BTNS; i++) begin
      if (!found && (i > 32'(last_grant)) && (slot[i] != EVT_NONE)) begin
        found      = 1'b1;
        grant_idx  = 3'(i);
        grant_type = slot[i];
      end
    end
    for (int unsigned i = 0; i < NUM_BTNS; i++) begin
      if (!found && (i <= 32'(last_grant)) && (slot[i] != EVT_NONE)) begin
        found      = 1'b1;
        grant_idx  = 3'(i);
        grant_type = slot[i];
      end
    end
  end

  // An event is lost when it lands on a pending slot that is not being granted
  always_comb begin
    drop_set = 1'b0;
    for (int unsigned i = 0; i < NUM_BTNS; i++) begin
      if ((new_evt[i] != EVT_NONE) && (slot[i] != EVT_NONE) &&
          !(grant && (grant_idx == 3'(i))))
        drop_set = 1'b1;
    end
  end

  // Pending slots: new events overwrite, grants clear
  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < NUM_BTNS; i++) begin
      if (!reset)                             slot[i] <= EVT_NONE;
      else if (new_evt[i] != EVT_NONE)        slot[i] <= new_evt[i];
      else if (grant && (grant_idx == 3'(i))) slot[i] <= EVT_NONE;
    end
  end

  // Last granted button; reset value makes button 0 win the first scan
  always_ff @(posedge clk) begin
    if (!reset)     last_grant <= 3'(NUM_BTNS - 1);
    else if (grant) last_grant <= grant_idx;
  end

  // Sticky drop flag; a new drop beats a simultaneous clear
  always_ff @(posedge clk) begin
    if (!reset)        evtDropped <= 1'b0;
    else if (drop_set) evtDropped <= 1'b1;
    else if (dropClr)  evtDropped <= 1'b0;
  end

  // FIFO storage, written on every grant
  always_ff @(posedge clk) begin
    if (grant) mem[wr_ptr] <= {grant_idx, grant_type};
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (grant) wr_ptr <= wr_ptr + 1'b1;
      if (pop)   rd_ptr <= rd_ptr + 1'b1;
      if (grant && !pop)      count <= count + 1'b1;
      else if (!grant && pop) count <= count - 1'b1;
    end
  end

  assign head     = mem[rd_ptr];
  assign evtValid = (count != '0);

  // Head event outputs, forced to zero while the FIFO is empty
  always_comb begin
    evtBtn  = '0;
    evtType = '0;
    if (evtValid) begin
      evtBtn  = head[4:2];
      evtType = head[1:0];
    end
  end

endmodule

// File: tb/tb_btn_event_scheduler.sv
// Directed bench for btn_event_scheduler with a 10-cycle millisecond tick,
// 4 ms first repeat and 2 ms repeat rate, four buttons and a 4-deep FIFO.
module tb_btn_event_scheduler;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] btnLevel;
  logic       evtValid;
  logic       evtReady;
  logic [2:0] evtBtn;
  logic [1:0] evtType;
  logic       evtDropped;
  logic       dropClr;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  btn_event_scheduler #(
    .NUM_BTNS       (4),
    .CLKIN_FREQ     (10000),
    .REPEAT_DELAY_MS(4),
    .REPEAT_RATE_MS (2),
    .FIFO_DEPTH     (4)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .btnLevel  (btnLevel),
    .evtValid  (evtValid),
    .evtReady  (evtReady),
    .evtBtn    (evtBtn),
    .evtType   (evtType),
    .evtDropped(evtDropped),
    .dropClr   (dropClr)
  );

  always #5 clk = ~clk;

  // Edges seen with reset high since the last reset; mirrors prescaler phase
  always @(posedge clk) cyc <= reset ? cyc + 1 : 0;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    btnLevel = 4'b0000;
    dropClr  = 1'b0;
    reset    = 1'b0;
    tick(2);
    reset    = 1'b1;
  endtask

  int saw;
  int guard;
  int nev;
  int nexp;
  int ev_i [8];
  int ev_t [8];
  int ev_b [8];
  int ex_i [8];
  int ex_t [8];
  int d_btn [5];
  int d_typ [5];

  initial begin
    // Reset with button 1 already held
    reset    = 1'b0;
    btnLevel = 4'b0010;
    evtReady = 1'b1;
    dropClr  = 1'b0;
    tick(3);
    check("rst_valid", 32'(evtValid), 0);
    check("rst_btn", 32'(evtBtn), 0);
    check("rst_type", 32'(evtType), 0);
    check("rst_dropped", 32'(evtDropped), 0);
    reset = 1'b1;
    saw = 0;
    repeat (200) begin
      tick(1);
      if (evtValid !== 1'b0) saw++;
    end
    check("held_through_reset_silent", 32'(saw), 0);

    // Press / release latency
    do_reset();
    btnLevel = 4'b0001;
    tick(1);
    check("press_n1_valid", 32'(evtValid), 0);
    tick(1);
    check("press_n2_valid", 32'(evtValid), 1);
    check("press_btn", 32'(evtBtn), 0);
    check("press_type", 32'(evtType), 1);
    tick(1);
    check("press_popped", 32'(evtValid), 0);
    btnLevel = 4'b0000;
    tick(1);
    check("rel_n1_valid", 32'(evtValid), 0);
    tick(1);
    check("rel_n2_valid", 32'(evtValid), 1);
    check("rel_btn", 32'(evtBtn), 0);
    check("rel_type", 32'(evtType), 2);
    tick(1);
    check("rel_popped", 32'(evtValid), 0);

    // Hold button 2 for 100 cycles, aligned so the first tick lands 4 edges after the change
    do_reset();
    guard = 0;
    while (((cyc % 10) != 6) && (guard < 20)) begin
      tick(1);
      guard++;
    end
    check("tick_align", 32'(cyc % 10), 6);
    for (int k = 0; k < 8; k++) begin
      ev_i[k] = -1; ev_t[k] = -1; ev_b[k] = -1;
      ex_i[k] = -1; ex_t[k] = -1;
    end
`ifdef BTN_AUTOREPEAT_EN
    nexp = 6;
    ex_i[0] = 2;   ex_t[0] = 1;
    ex_i[1] = 35;  ex_t[1] = 3;
    ex_i[2] = 55;  ex_t[2] = 3;
    ex_i[3] = 75;  ex_t[3] = 3;
    ex_i[4] = 95;  ex_t[4] = 3;
    ex_i[5] = 102; ex_t[5] = 2;
`else
    nexp = 2;
    ex_i[0] = 2;   ex_t[0] = 1;
    ex_i[1] = 102; ex_t[1] = 2;
`endif
    nev = 0;
    btnLevel = 4'b0100;
    for (int i = 1; i <= 115; i++) begin
      tick(1);
      if (evtValid === 1'b1) begin
        if (nev < 8) begin
          ev_i[nev] = i;
          ev_t[nev] = int'(evtType);
          ev_b[nev] = int'(evtBtn);
        end
        nev++;
      end
      if (i == 100) btnLevel = 4'b0000;
    end
    check("hold_event_count", 32'(nev), 32'(nexp));
    for (int k = 0; k < nexp; k++) begin
      check($sformatf("hold_evt%0d_cycle", k), 32'(ev_i[k]), 32'(ex_i[k]));
      check($sformatf("hold_evt%0d_type", k), 32'(ev_t[k]), 32'(ex_t[k]));
      check($sformatf("hold_evt%0d_btn", k), 32'(ev_b[k]), 2);
    end
    check("hold_no_drop", 32'(evtDropped), 0);

    // Simultaneous press of all four with the consumer stalled
    do_reset();
    evtReady = 1'b0;
    btnLevel = 4'b1111;
    tick(8);
    check("fill_valid", 32'(evtValid), 1);
    check("fill_head_btn", 32'(evtBtn), 0);
    evtReady = 1'b1;
    for (int k = 0; k < 4; k++) begin
      check($sformatf("drain%0d_valid", k), 32'(evtValid), 1);
      check($sformatf("drain%0d_btn", k), 32'(evtBtn), 32'(k));
      check($sformatf("drain%0d_type", k), 32'(evtType), 1);
      tick(1);
    end
    check("drain_empty", 32'(evtValid), 0);
    check("fill_no_drop", 32'(evtDropped), 0);

    // Overwrite a pending slot while the FIFO is full
    do_reset();
    evtReady = 1'b0;
    btnLevel = 4'b1101;
    tick(6);
    btnLevel = 4'b1100;
    tick(4);
    check("full_no_drop_yet", 32'(evtDropped), 0);
    btnLevel = 4'b1110;
    tick(2);
    btnLevel = 4'b1100;
    tick(2);
    check("overwrite_dropped", 32'(evtDropped), 1);
    check("overwrite_head_btn", 32'(evtBtn), 0);
    dropClr = 1'b1;
    tick(1);
    dropClr = 1'b0;
    check("dropclr_clears", 32'(evtDropped), 0);
    d_btn[0] = 0; d_typ[0] = 1;
    d_btn[1] = 2; d_typ[1] = 1;
    d_btn[2] = 3; d_typ[2] = 1;
    d_btn[3] = 0; d_typ[3] = 2;
    d_btn[4] = 1; d_typ[4] = 2;
    evtReady = 1'b1;
    for (int k = 0; k < 5; k++) begin
      check($sformatf("ovw%0d_valid", k), 32'(evtValid), 1);
      check($sformatf("ovw%0d_btn", k), 32'(evtBtn), 32'(d_btn[k]));
      check($sformatf("ovw%0d_type", k), 32'(evtType), 32'(d_typ[k]));
      tick(1);
    end
    check("ovw_empty", 32'(evtValid), 0);

    // Reset pulse with three events queued
    do_reset();
    evtReady = 1'b0;
    btnLevel = 4'b0111;
    tick(6);
    check("queued_valid", 32'(evtValid), 1);
    reset = 1'b0;
    tick(1);
    check("midrst_valid", 32'(evtValid), 0);
    check("midrst_btn", 32'(evtBtn), 0);
    check("midrst_type", 32'(evtType), 0);
    reset = 1'b1;
    evtReady = 1'b1;
    saw = 0;
    repeat (30) begin
      tick(1);
      if (evtValid !== 1'b0) saw++;
    end
    check("no_stale_after_reset", 32'(saw), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/btn_event_scheduler.md
Name: btn_event_scheduler

Overview:
- Sits between the per-button debouncer instances and the game logic.
- Turns debounced button levels into discrete events: press, release and hold auto-repeat.
- Round-robin arbitration serialises events from all buttons into a small first-word-fall-through (FWFT) FIFO.
- Game logic drains the FIFO through a valid/ready handshake.

Parameters:
- NUM_BTNS, 4: number of debounced button inputs; range 2..8.
- CLKIN_FREQ, 27000000: clock frequency in Hz. Millisecond prescaler period TICK_CYC = CLKIN_FREQ/1000 cycles.
- REPEAT_DELAY_MS, 400: hold time in ms before the first repeat event.
- REPEAT_RATE_MS, 100: interval in ms between subsequent repeat events.
- FIFO_DEPTH, 4: event FIFO depth; power of 2, minimum 2.

Ports:
- clk  in  1: system clock.
- reset  in  1: reset, synchronous and active-low.
- btnLevel  in  NUM_BTNS: debounced button levels; 1 = pressed; synchronous to clk.
- evtValid  out  1: FIFO head holds an event.
- evtReady  in  1: consumer accepts the head event.
- evtBtn  out  3: button index of the head event.
- evtType  out  2: 01 = press, 10 = release, 11 = repeat. Never 00 while evtValid = 1.
- evtDropped  out  1: sticky flag; an event was lost.
- dropClr  in  1: clears evtDropped.

Behaviour:
- Reset: clk is the only clock; reset is synchronous and active-low.
  - While reset=0 at a clk edge, all outputs go to 0 (evtValid, evtBtn, evtType, evtDropped).
  - FIFO empties, all pending slots clear, the prescaler and all hold counters clear.
  - The btnLevel history register loads the current btnLevel, so buttons already held at reset release produce no press event.
  - Reset asserted mid-operation discards queued and pending events without emitting them.
- Edge detection: btnQ is registered each cycle. Comparing btnLevel against btnQ gives 0->1 = press and 1->0 = release.
- Pending slot per button:
  - 2-bit register; 00 = empty, otherwise holds the event type.
  - A new event for a button whose slot is non-empty overwrites the slot and sets evtDropped.
- Arbiter:
  - Each cycle, scans pending slots round-robin starting at lastGrant+1 (mod NUM_BTNS).
  - Grants the first non-empty slot when the FIFO can accept: not full, or full with a pop in the same cycle.
  - On grant, pushes {index, type}, clears the slot and updates lastGrant.
  - Maximum one push per cycle.
  - A slot that is cleared by the grant and receives a new event in the same cycle ends up holding the new event.
- FIFO: FWFT. Pop when evtValid && evtReady. Push and pop in the same cycle are allowed at any occupancy, including full and empty.
- Latency: btnLevel change at edge N with FIFO empty and no competing slots gives evtValid=1 after edge N+2 (slot set at N+1, push at N+2).
- Prescaler:
  - Free-running counter 0..TICK_CYC-1.
  - tick=1 for one cycle when the counter equals TICK_CYC-1.
- Hold counter per button:
  - Width covers max(REPEAT_DELAY_MS, REPEAT_RATE_MS).
  - Clears on press, and every cycle the button is released.
  - While held, it increments on tick.
  - When it reaches REPEAT_DELAY_MS (first repeat) or REPEAT_RATE_MS (later repeats), it posts a repeat event to the slot and reloads to 0.
  - A per-button firstDone bit selects which threshold applies and clears on release.
- Event priority for one button in one cycle: a release wins over a repeat.
- evtDropped: set on any overwrite. dropClr clears it, but a set in the same cycle wins over the clear.
- No event is generated while reset=0.

Optional Feature:
- Macro BTN_AUTOREPEAT_EN.
- Defined: prescaler, hold counters, firstDone bits and repeat events are present as described above.
- Undefined: this logic is not built. evtType never takes the value 11. REPEAT_DELAY_MS and REPEAT_RATE_MS are ignored. Press/release behaviour and latency are unchanged.

Test Plan:
- Setup for all scenarios: CLKIN_FREQ=10000 (TICK_CYC=10), REPEAT_DELAY_MS=4, REPEAT_RATE_MS=2, NUM_BTNS=4, FIFO_DEPTH=4, BTN_AUTOREPEAT_EN defined, evtReady=1 unless stated.
- Reset with btnLevel=0010, then release reset and hold the level -> no event emitted; evtValid stays 0 for 200 cycles.
- btnLevel 0000->0001 at edge N -> evtValid=1, evtBtn=0, evtType=01 after edge N+2, popped the next cycle. Drop to 0000 -> evtType=10 under the same latency.
- Hold button 2 for 100 cycles -> press, then repeats at 40±10 cycles and every 20 cycles after the first. Exactly 4 repeats, then a release. evtDropped stays 0.
- evtReady=0 and btnLevel 0000->1111 in one cycle -> FIFO fills with press events for buttons 0,1,2,3 in that order. Raise evtReady -> drained in that order, no drops.
- evtReady=0, FIFO full, press then release button 1 while its slot is still pending -> evtDropped=1 and the slot holds the release. dropClr=1 for one cycle -> evtDropped=0.
- Assert reset=0 for one cycle with 3 events queued -> evtValid=0 on the next cycle; no stale event is emitted after reset releases.
